// File: rtl/probe_scheduler.sv
// probe_scheduler: periodic latency probes with req/ack launch, echo matching, timeout and loss/skip counting
module probe_scheduler #(
  parameter int SOURCE_CLK     = 100000000,
  parameter int PROBE_HZ       = 10,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int LAT_W          = 32,
  parameter int SEQ_W          = 16
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_enable,
  output logic             out_tx_req,
  output logic [SEQ_W-1:0] out_tx_seq,
  input  logic             in_tx_ack,
  input  logic             in_rx_valid,
  input  logic [SEQ_W-1:0] in_rx_seq,
  output logic             out_result_valid,
  output logic [LAT_W-1:0] out_latency,
  output logic [SEQ_W-1:0] out_result_seq,
  output logic             out_timeout,
  output logic [15:0]      out_lost_count,
  output logic [15:0]      out_skip_count,
  output logic             out_busy
);
  localparam int PERIOD = SOURCE_CLK / PROBE_HZ;
  localparam int PW = $clog2(PERIOD);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RX, REPORT} state_t;
  state_t           state_q;
  logic [PW-1:0]    per_q, per_d;
  logic [LAT_W-1:0] lat_q, latency_q;
  logic [SEQ_W-1:0] seq_q, tx_seq_q, res_seq_q;
  logic [15:0]      lost_q, skip_q;
  logic             tx_req_q, res_valid_q, timeout_q, tick, match, expired;
  assign tick    = in_enable && per_q == PW'(PERIOD - 1);
  assign match   = in_rx_valid && in_rx_seq == seq_q;
  assign expired = lat_q == LAT_W'(TIMEOUT_CYCLES);
  always_comb begin
    per_d = !in_enable ? '0 : (per_q == PW'(PERIOD - 1)) ? '0 : per_q + PW'(1);
  end
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q     <= IDLE;
      per_q       <= '0;
      lat_q       <= '0;
      latency_q   <= '0;
      seq_q       <= '0;
      tx_seq_q    <= '0;
      res_seq_q   <= '0;
      lost_q      <= '0;
      skip_q      <= '0;
      tx_req_q    <= 1'b0;
      res_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      per_q <= per_d;
      if (tick && state_q != IDLE && skip_q != 16'hFFFF) skip_q <= skip_q + 16'd1;
      case (state_q)
        IDLE: if (tick) begin
          state_q  <= REQ;
          tx_req_q <= 1'b1;
          tx_seq_q <= seq_q;
        end
        REQ: if (in_tx_ack) begin
          state_q  <= WAIT_RX;
          tx_req_q <= 1'b0;
          lat_q    <= LAT_W'(1);
        end
        WAIT_RX: begin
          lat_q <= lat_q + LAT_W'(1);
          // a matching echo on the timeout cycle still counts as a delivery
          if (match || expired) begin
            state_q     <= REPORT;
            res_valid_q <= 1'b1;
            res_seq_q   <= seq_q;
            latency_q   <= match ? lat_q : LAT_W'(TIMEOUT_CYCLES);
            timeout_q   <= !match;
            if (!match && lost_q != 16'hFFFF) lost_q <= lost_q + 16'd1;
          end
        end
        REPORT: begin
          state_q     <= IDLE;
          res_valid_q <= 1'b0;
          seq_q       <= seq_q + SEQ_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign out_tx_req       = tx_req_q;
  assign out_tx_seq       = tx_seq_q;
  assign out_result_valid = res_valid_q;
  assign out_latency      = latency_q;
  assign out_result_seq   = res_seq_q;
  assign out_timeout      = timeout_q;
  assign out_lost_count   = lost_q;
  assign out_skip_count   = skip_q;
  assign out_busy         = state_q != IDLE;
endmodule

// File: tb/tb_probe_scheduler.sv
// tb_probe_scheduler: randomized probes checked against a cycle-arithmetic model of ticks, latency and counts
module tb_probe_scheduler;
  localparam int T = 50;
  localparam int P = 100;
  logic        clk = 0, rst = 1, en = 0, ack = 0, rxv = 0;
  logic [15:0] rxs = 0;
  logic        tx_req, res_valid, timeout, busy;
  logic [15:0] tx_seq, res_seq, lost, skip;
  logic [31:0] latency;
  logic        en2 = 0, ack2 = 0, rxv2 = 0;
  logic [1:0]  rxs2 = 0;
  logic        tx_req2, res_valid2, timeout2, busy2;
  logic [1:0]  tx_seq2, res_seq2;
  logic [15:0] lost2, skip2;
  logic [31:0] latency2;
  int checks = 0, errors = 0, cyc = 0;
  int e_cyc = 0, en_off = 1 << 30, last_idle = 0, seq_m = 0, lost_m = 0, skip_m = 0;
  always #5 clk = ~clk;
  probe_scheduler #(.SOURCE_CLK(1000), .PROBE_HZ(10), .TIMEOUT_CYCLES(T), .LAT_W(32), .SEQ_W(16)) dut (
    .in_clk(clk), .in_rst(rst), .in_enable(en), .out_tx_req(tx_req), .out_tx_seq(tx_seq),
    .in_tx_ack(ack), .in_rx_valid(rxv), .in_rx_seq(rxs), .out_result_valid(res_valid),
    .out_latency(latency), .out_result_seq(res_seq), .out_timeout(timeout),
    .out_lost_count(lost), .out_skip_count(skip), .out_busy(busy));
  probe_scheduler #(.SOURCE_CLK(20), .PROBE_HZ(10), .TIMEOUT_CYCLES(T), .LAT_W(32), .SEQ_W(2)) dut2 (
    .in_clk(clk), .in_rst(rst), .in_enable(en2), .out_tx_req(tx_req2), .out_tx_seq(tx_seq2),
    .in_tx_ack(ack2), .in_rx_valid(rxv2), .in_rx_seq(rxs2), .out_result_valid(res_valid2),
    .out_latency(latency2), .out_result_seq(res_seq2), .out_timeout(timeout2),
    .out_lost_count(lost2), .out_skip_count(skip2), .out_busy(busy2));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  function automatic bit is_tick(int c);
    int first = e_cyc + P - 1;
    return c >= first && c < en_off && (c - first) % P == 0;
  endfunction
  function automatic int ticks_in(int a, int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (is_tick(c)) n++;
    return n;
  endfunction
  function automatic int next_tick(int a);
    for (int c = a; c < a + 1000; c++) if (is_tick(c)) return c;
    return -1;
  endfunction
  task automatic probe(input int d, input int n, input bit stale, input bit stray, input bit sat, input bit drop);
    int k, r, rq, lat_e;
    bit to_e, got;
    rq = next_tick(last_idle) + 1;
    for (int i = 0; i < 400 && !tx_req; i++) step;
    chk("req_cycle", cyc, rq);
    chk("tx_seq", tx_seq, seq_m);
    if (sat) begin
      force dut.skip_q = 16'hFFFE;
      step;
      release dut.skip_q;
      skip_m = 16'hFFFE;
    end
    while (cyc < rq + d) step;
    if (d > 0) chk("req_held", tx_req, 1);
    ack = 1;
    k = cyc;
    step;
    ack = 0;
    chk("req_drop", tx_req, 0);
    chk("busy_wait", busy, 1);
    if (drop) begin
      en = 0;
      en_off = cyc;
    end
    to_e = n > T;
    lat_e = to_e ? T : n;
    r = k + lat_e + 1;
    got = 0;
    for (int i = 1; i <= T + 3 && !got; i++) begin
      rxv = (i == n) || (stale && i == 3 && n != 3);
      rxs = (stale && i == 3 && n != 3) ? 16'(seq_m - 1) : 16'(seq_m);
      ack = stray && i == 2;
      step;
      rxv = 0;
      ack = 0;
      if (res_valid) begin
        got = 1;
        if (to_e && lost_m < 16'hFFFF) lost_m++;
        chk("res_cycle", cyc, r);
        chk("latency", latency, lat_e);
        chk("timeout", timeout, to_e);
        chk("res_seq", res_seq, seq_m);
        chk("lost", lost, lost_m);
      end
    end
    chk("res_seen", got, 1);
    skip_m = skip_m + ticks_in(rq, r);
    if (skip_m > 16'hFFFF) skip_m = 16'hFFFF;
    step;
    chk("pulse_end", res_valid, 0);
    chk("skip", skip, skip_m);
    if (to_e) begin
      rxv = 1;
      rxs = 16'(seq_m);
      step;
      rxv = 0;
      chk("late_echo", res_valid, 0);
      chk("lat_hold", latency, T);
    end
    seq_m = (seq_m + 1) & 16'hFFFF;
    last_idle = r + 1;
  endtask
  initial begin
    repeat (3) step;
    rst = 0;
    step;
    chk("rst_req", tx_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_lat", latency, 0);
    chk("rst_lost", lost, 0);
    chk("rst_skip", skip, 0);
    en2 = 1;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 20 && !tx_req2; j++) step;
      chk("wrap_req", tx_req2, 1);
      ack2 = 1;
      step;
      ack2 = 0;
      rxv2 = 1;
      rxs2 = tx_seq2;
      step;
      rxv2 = 0;
      chk("wrap_valid", res_valid2, 1);
      chk("wrap_seq", res_seq2, i % 4);
      chk("wrap_lat", latency2, 1);
      step;
    end
    en2 = 0;
    en = 1;
    e_cyc = cyc;
    last_idle = cyc;
    probe(2, 10, 0, 0, 0, 0);
    probe(5, 70, 0, 0, 0, 0);
    repeat (3) probe($urandom_range(0, 130), $urandom_range(1, 60), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    probe(3, 50, 1, 1, 0, 0);
    probe(150, 5, 0, 0, 0, 0);
    probe(160, 5, 0, 0, 1, 0);
    repeat (15) probe($urandom_range(0, 130), $urandom_range(1, 60), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
    probe(4, 20, 0, 0, 0, 1);
    begin
      bit saw = 0;
      repeat (250) begin
        step;
        if (tx_req) saw = 1;
      end
      chk("no_req_after_drop", saw, 0);
    end
    en = 1;
    e_cyc = cyc;
    en_off = 1 << 30;
    last_idle = cyc;
    for (int i = 0; i < 400 && !tx_req; i++) step;
    chk("rst_test_req", tx_req, 1);
    ack = 1;
    step;
    ack = 0;
    step;
    step;
    chk("pre_rst_busy", busy, 1);
    rst = 1;
    step;
    rst = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_req", tx_req, 0);
    chk("mid_rst_seq", tx_seq, 0);
    chk("mid_rst_lat", latency, 0);
    chk("mid_rst_rseq", res_seq, 0);
    chk("mid_rst_to", timeout, 0);
    chk("mid_rst_lost", lost, 0);
    chk("mid_rst_skip", skip, 0);
    chk("mid_rst_valid", res_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/probe_scheduler.md
# probe_scheduler

Sequences periodic latency probes for the Ethernet latency checker. An internal period counter issues one probe per period. Each probe goes to the frame transmitter through a req/ack handshake, and the block waits for the echo carrying the matching sequence number. It times the round trip in `in_clk` cycles, or declares a timeout, then reports one result pulse to the display/logging path. Running counts of lost probes and skipped periods are kept for status readout.

## Interface
Parameters:
- `SOURCE_CLK`, 100000000: `in_clk` frequency in Hz.
- `PROBE_HZ`, 10: probe rate in Hz. `PERIOD = SOURCE_CLK / PROBE_HZ`; `PERIOD` must be ≥ 2.
- `TIMEOUT_CYCLES`, 1000000: maximum wait for an echo in cycles, ≥ 1. Must be < 2^`LAT_W`.
- `LAT_W`, 32: latency field width.
- `SEQ_W`, 16: sequence number width.

Ports:
- `in_clk` in 1: single clock; all logic is on its rising edge.
- `in_rst` in 1: synchronous, active-high reset.
- `in_enable` in 1: high = schedule probes.
- `out_tx_req` out 1: probe request to the transmitter.
- `out_tx_seq` out `SEQ_W`: sequence number for the probe frame; stable while `out_tx_req` is high.
- `in_tx_ack` in 1: transmitter accepted the request (frame launched).
- `in_rx_valid` in 1: single-cycle pulse, echo frame received.
- `in_rx_seq` in `SEQ_W`: sequence number of the received echo; qualified by `in_rx_valid`.
- `out_result_valid` out 1: single-cycle result pulse.
- `out_latency` out `LAT_W`: round-trip cycles, or `TIMEOUT_CYCLES` on timeout.
- `out_result_seq` out `SEQ_W`: sequence number of the reported probe.
- `out_timeout` out 1: the reported probe timed out.
- `out_lost_count` out 16: count of timeouts, saturating at 0xFFFF.
- `out_skip_count` out 16: count of dropped ticks, saturating at 0xFFFF.
- `out_busy` out 1: high whenever the FSM is not in `IDLE`.

## Operation
- **Reset:** state `IDLE`; period counter, latency counter, sequence, both counts and every output = 0.
- **Period counter:** held at 0 while `in_enable` = 0. Otherwise it counts 0..`PERIOD`-1 and wraps. An internal tick is asserted for one cycle when count = `PERIOD`-1.
- **FSM `IDLE`:** on tick, go to `REQ`.
- **FSM `REQ`:** `out_tx_req` = 1 and `out_tx_seq` = current sequence. Hold until `in_tx_ack` is sampled high, then go to `WAIT_RX`.
- **FSM `WAIT_RX`:** the latency counter = 1 on the first cycle and increments by 1 each cycle after.
  - Match: `in_rx_valid` with `in_rx_seq` = current sequence. Latch the counter into `out_latency`, set `out_timeout` = 0, go to `REPORT`.
  - Non-matching `in_rx_valid` (a stale echo) is ignored.
  - If the counter = `TIMEOUT_CYCLES` with no match: `out_latency` = `TIMEOUT_CYCLES`, `out_timeout` = 1, go to `REPORT`.
  - If a match and the timeout occur in the same cycle, the match wins.
- **FSM `REPORT`:** `out_result_valid` = 1 for one cycle and `out_result_seq` = current sequence.
  - On timeout, `out_lost_count` increments (saturating).
  - The sequence increments, wrapping modulo 2^`SEQ_W`.
  - Next state is `IDLE`.
- **Skipped ticks:** a tick arriving while state ≠ `IDLE` is dropped, and `out_skip_count` increments (saturating). The period counter is not disturbed.
- **`in_enable` falling mid-probe:** the probe in flight completes normally through `REPORT`; no further ticks are generated.
- **Result holding:** `out_latency`, `out_result_seq` and `out_timeout` hold their values until the next `REPORT`.
- **`in_tx_ack` outside `REQ`:** ignored.

## Timing
- All outputs are registered.
- Tick in cycle t → `out_tx_req` high in cycle t+1.
- `in_tx_ack` sampled in cycle k → `out_tx_req` low in cycle k+1, and the latency counter = 1 in cycle k+1.
- Matching `in_rx_valid` in cycle k+n (n ≥ 1) → `out_result_valid` high in cycle k+n+1 with `out_latency` = n.
- With no echo, `out_result_valid` is high in cycle k+`TIMEOUT_CYCLES`+1.
- `in_enable` rising in cycle e → first tick in cycle e+`PERIOD`-1.
- `in_rst` is high-priority over all state in any cycle, including mid-`REQ` (`out_tx_req` drops on the next edge).

## Test plan
Bench parameters: `SOURCE_CLK` = 1000, `PROBE_HZ` = 10 (so `PERIOD` = 100), `TIMEOUT_CYCLES` = 50.

- **Basic probe:** `in_enable` rises at cycle 0 → `out_tx_req` high at cycle 100. `in_tx_ack` at cycle 102, echo with seq 0 at cycle 112 → `out_result_valid` at cycle 113 with `out_latency` = 10, `out_result_seq` = 0, `out_timeout` = 0. The next request carries `out_tx_seq` = 1.
- **Timeout:** ack with no echo → result 51 cycles after the ack cycle, with `out_latency` = 50, `out_timeout` = 1, `out_lost_count` = 1. An echo carrying seq 0 after that is ignored.
- **Stale echo and simultaneous events:** during probe seq 5, echo seq 4 at n = 3 → no result. Echo seq 5 at n = 50 (the same cycle as the timeout) → `out_latency` = 50, `out_timeout` = 0.
- **Skipped tick:** hold `in_tx_ack` low for 150 cycles → `out_skip_count` = 1, with `out_tx_req` continuously high. Further stalling saturates the count at 0xFFFF (force the count with a long run or preload in sim).
- **Sequence wrap:** with `SEQ_W` = 2, run 5 probes → `out_result_seq` reads 0, 1, 2, 3, 0.
- **Reset and enable mid-operation:** pulse `in_rst` during `WAIT_RX` → all outputs 0 next cycle and the FSM returns to `IDLE`. Drop `in_enable` during `WAIT_RX` → the result is still reported and no further `out_tx_req` occurs.
